i2s_rx: RTL

Upstream I2S receiver for the audio path. Oversamples the ADC's I2S bus (I2S_SCLK, I2S_LRCLK, I2S_DOUT) in the system clock domain and deserializes one left and one right sample per frame. Delivers both as parallel words with a single-cycle valid strobe, for use by the playback/mixing logic that feeds the DAC serializer. Handles slots longer than DATA_W by truncation and flags malformed frames.

---
 rtl/i2s_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver; deserializes one left/right pair per frame.
module i2s_rx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              I2S_SCLK,
  input  logic              I2S_LRCLK,
  input  logic              I2S_DOUT,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAD
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] dout_sync;
  logic                   s_sclk;
  logic                   s_sclk_d;
  logic                   s_lr;
  logic                   s_dout;
  logic                   sclk_rise;
  logic                   bit_q;
  logic                   lr_q;
  logic                   boundary;

  state_t                 state;
  logic                   lr_prev;
  logic                   ch;
  logic                   left_ok;
  logic                   valid_pend;
  logic                   err_pend;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_W-1:0]      sreg;
  logic [DATA_W-1:0]      sreg_next;
  logic [DATA_W-1:0]      left_stage;

  assign s_sclk    = sclk_sync[SYNC_STAGES-1];
  assign s_lr      = lr_sync[SYNC_STAGES-1];
  assign s_dout    = dout_sync[SYNC_STAGES-1];
  assign boundary  = sclk_rise & (lr_q != lr_prev);
  assign sreg_next = {sreg[DATA_W-2:0], bit_q};

  // Identical synchronizer chains keep SCLK, LRCLK and DOUT mutually aligned
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      dout_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], I2S_SCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], I2S_LRCLK};
      dout_sync <= {dout_sync[SYNC_STAGES-2:0], I2S_DOUT};
    end
  end

  // SCLK rising-edge detect, registered together with the bit and word select it qualifies
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_sclk_d  <= 1'b0;
      sclk_rise <= 1'b0;
      bit_q     <= 1'b0;
      lr_q      <= 1'b0;
    end else begin
      s_sclk_d  <= s_sclk;
      sclk_rise <= s_sclk & ~s_sclk_d;
      bit_q     <= s_dout;
      lr_q      <= s_lr;
    end
  end

  // Frame FSM: the bit on each LRCLK boundary is the one-bit-delay bit and is skipped
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      lr_prev    <= 1'b1;
      ch         <= 1'b0;
      cnt        <= '0;
      left_ok    <= 1'b0;
      sreg       <= '0;
      left_stage <= '0;
      left_data  <= '0;
      right_data <= '0;
      valid_pend <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      valid_pend <= 1'b0;
      err_pend   <= 1'b0;
      if (sclk_rise) begin
        lr_prev <= lr_q;
        case (state)
          IDLE: begin
            left_ok <= 1'b0;
            if (boundary && !lr_q) begin
              state <= SHIFT;
              ch    <= 1'b0;
              cnt   <= '0;
            end
          end
          SHIFT: begin
            if (boundary) begin
              // Slot ended before a full word: drop the partial frame
              state    <= IDLE;
              left_ok  <= 1'b0;
              err_pend <= 1'b1;
            end else begin
              sreg <= sreg_next;
              cnt  <= cnt + CNT_W'(1);
              if (cnt == CNT_LAST) begin
                state <= PAD;
                if (!ch) begin
                  left_stage <= sreg_next;
                  left_ok    <= 1'b1;
                end else if (left_ok) begin
                  left_data  <= left_stage;
                  right_data <= sreg_next;
                  valid_pend <= 1'b1;
                  left_ok    <= 1'b0;
                end
              end
            end
          end
          PAD: begin
            if (boundary) begin
              state <= SHIFT;
              ch    <= lr_q;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output strobes trail the commit / error decision by one cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= valid_pend;
      frame_err    <= err_pend;
    end
  end

endmodule
